// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution address scheduler.
// Contents:
//   sched_state_e  - scheduler FSM states
//   TAPS, KDIM     - 3x3 kernel geometry
//   array_mode_e   - mode codes shared with the array controller
package conv_sched_pkg;

    localparam int unsigned KDIM = 3;
    localparam int unsigned TAPS = KDIM * KDIM;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSetup = 3'd1,
        StIssue = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        ModeConfig  = 2'b00,
        ModeLoad    = 2'b01,
        ModeCompute = 2'b10
    } array_mode_e;

endpackage

// File: rtl/sched_tag_pipe.sv
// Fixed-latency delay line for the read tags, so that the tags leave the pipe
// in the same cycle as the memory read data.
// Ports:
//   clk   in   clock
//   rstn  in   synchronous active-low clear of every stage
//   din   in   TAG_W  tag launched alongside the memory request
//   dout  out  TAG_W  tag delayed by exactly LAT cycles
module sched_tag_pipe #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned TAG_W = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [TAG_W-1:0] din,
    output logic [TAG_W-1:0] dout
);

    logic [LAT*TAG_W-1:0] sr_q;

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= din;
                end
            end
        end else begin : g_multi
            // Newest tag enters at the low end, oldest leaves at the top.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= {sr_q[(LAT-1)*TAG_W-1:0], din};
                end
            end
        end
    endgenerate

    assign dout = sr_q[LAT*TAG_W-1 -: TAG_W];

endmodule

// File: rtl/conv_addr_sched.sv
// Convolution address scheduler: walks 3x3 windows over a channel-major input
// memory (addr = c*W*H + y*W + x) and issues one read per cycle the array is
// ready. Tags {valid,row,tap,last} travel through a MEM_LAT delay so they line
// up with the memory read data. Output pixels are dealt round-robin over ROWS.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start                1-cycle pulse, accepted only in idle
//   cfg_width/height     input plane W/H, latched on an accepted start
//   cfg_chans            channel count C, latched on an accepted start
//   arr_ready            array can take a word; gates issue
//   mem_cen, mem_addr    memory request (chip enable active low)
//   feed_valid/row/tap/last  tags aligned with memory read data
//   busy, done, err      job status (err held until next accepted start)
// ROWS must be at least 2.
module conv_addr_sched
    import conv_sched_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DIM_W   = 8,
    parameter int unsigned CH_W    = 8,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [DIM_W-1:0]         cfg_width,
    input  logic [DIM_W-1:0]         cfg_height,
    input  logic [CH_W-1:0]          cfg_chans,
    input  logic                     arr_ready,
    output logic                     mem_cen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     feed_valid,
    output logic [$clog2(ROWS)-1:0]  feed_row,
    output logic [3:0]               feed_tap,
    output logic                     feed_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned TOT_W = CH_W + 2 * DIM_W;
    localparam int unsigned CMP_W = ((TOT_W > ADDR_W) ? TOT_W : ADDR_W) + 1;
    localparam int unsigned TAG_W = 1 + ROW_W + 4 + 1;
    localparam int unsigned DRN_W = $clog2(MEM_LAT + 1);

    sched_state_e state_q;

    // Latched job configuration
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  h_q;
    logic [CH_W-1:0]   c_q;
    logic [ADDR_W-1:0] plane_q;

    // Loop counters and incremental address bases
    logic [DIM_W-1:0]  ox_q;
    logic [DIM_W-1:0]  oy_q;
    logic [CH_W-1:0]   ch_q;
    logic [1:0]        ky_q;
    logic [1:0]        kx_q;
    logic [3:0]        tap_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] chan_base_q;  // c*W*H
    logic [ADDR_W-1:0] out_base_q;   // oy*W + ox
    logic [ADDR_W-1:0] row_off_q;    // ky*W
    logic [DRN_W-1:0]  drain_cnt_q;

    // Registered outputs and the tag launched with each request
    logic              mem_cen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              iss_valid_q;
    logic [ROW_W-1:0]  iss_row_q;
    logic [3:0]        iss_tap_q;
    logic              iss_last_q;

    // Setup-time size checks; these are the only multipliers in the block.
    logic [2*DIM_W-1:0] plane_full;
    logic [TOT_W-1:0]   total_full;
    logic [CMP_W-1:0]   total_ext;
    logic [CMP_W-1:0]   total_limit;
    logic               cfg_bad;

    assign plane_full  = {{DIM_W{1'b0}}, w_q} * {{DIM_W{1'b0}}, h_q};
    assign total_full  = TOT_W'(c_q) * TOT_W'(plane_full);
    assign total_ext   = CMP_W'(total_full);
    assign total_limit = CMP_W'(1) << ADDR_W;
    assign cfg_bad     = (w_q < DIM_W'(KDIM)) || (h_q < DIM_W'(KDIM)) || (c_q == '0) ||
                         (total_ext > total_limit);

    // Window position decode
    logic              kx_wrap;
    logic              ky_wrap;
    logic              ch_wrap;
    logic              ox_wrap;
    logic              oy_wrap;
    logic              is_last;
    logic [ADDR_W-1:0] issue_addr;

    assign kx_wrap = (kx_q == 2'(KDIM - 1));
    assign ky_wrap = (ky_q == 2'(KDIM - 1));
    assign ch_wrap = (ch_q == c_q - CH_W'(1));
    assign ox_wrap = (ox_q == w_q - DIM_W'(KDIM));
    assign oy_wrap = (oy_q == h_q - DIM_W'(KDIM));
    assign is_last = kx_wrap && ky_wrap && ch_wrap && ox_wrap && oy_wrap;

    // Modulo 2^ADDR_W by construction of the operand widths.
    assign issue_addr = chan_base_q + out_base_q + row_off_q + ADDR_W'(kx_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            w_q         <= '0;
            h_q         <= '0;
            c_q         <= '0;
            plane_q     <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            ch_q        <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            tap_q       <= '0;
            row_q       <= '0;
            chan_base_q <= '0;
            out_base_q  <= '0;
            row_off_q   <= '0;
            drain_cnt_q <= '0;
            mem_cen_q   <= 1'b1;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_row_q   <= '0;
            iss_tap_q   <= '0;
            iss_last_q  <= 1'b0;
        end else begin
            mem_cen_q   <= 1'b1;
            done_q      <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_row_q   <= '0;
            iss_tap_q   <= '0;
            iss_last_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        w_q     <= cfg_width;
                        h_q     <= cfg_height;
                        c_q     <= cfg_chans;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSetup;
                    end
                end

                StSetup: begin
                    plane_q     <= ADDR_W'(plane_full);
                    ox_q        <= '0;
                    oy_q        <= '0;
                    ch_q        <= '0;
                    ky_q        <= '0;
                    kx_q        <= '0;
                    tap_q       <= '0;
                    row_q       <= '0;
                    chan_base_q <= '0;
                    out_base_q  <= '0;
                    row_off_q   <= '0;
                    if (cfg_bad) begin
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StIssue;
                    end
                end

                StIssue: begin
                    if (arr_ready) begin
                        mem_cen_q   <= 1'b0;
                        mem_addr_q  <= issue_addr;
                        iss_valid_q <= 1'b1;
                        iss_row_q   <= row_q;
                        iss_tap_q   <= tap_q;
                        iss_last_q  <= is_last;

                        tap_q <= (tap_q == 4'(TAPS - 1)) ? 4'd0 : tap_q + 4'd1;

                        // Innermost kx, then ky, then channel, then output pixel.
                        if (!kx_wrap) begin
                            kx_q <= kx_q + 2'd1;
                        end else begin
                            kx_q <= '0;
                            if (!ky_wrap) begin
                                ky_q      <= ky_q + 2'd1;
                                row_off_q <= row_off_q + ADDR_W'(w_q);
                            end else begin
                                ky_q      <= '0;
                                row_off_q <= '0;
                                if (!ch_wrap) begin
                                    ch_q        <= ch_q + CH_W'(1);
                                    chan_base_q <= chan_base_q + plane_q;
                                end else begin
                                    ch_q        <= '0;
                                    chan_base_q <= '0;
                                    row_q <= (row_q == ROW_W'(ROWS - 1)) ? '0
                                                                          : row_q + ROW_W'(1);
                                    if (!ox_wrap) begin
                                        ox_q       <= ox_q + DIM_W'(1);
                                        out_base_q <= out_base_q + ADDR_W'(1);
                                    end else begin
                                        // oy*W + (W-3) + 3 lands on the next row start.
                                        ox_q       <= '0;
                                        oy_q       <= oy_q + DIM_W'(1);
                                        out_base_q <= out_base_q + ADDR_W'(KDIM);
                                    end
                                end
                            end
                        end

                        if (is_last) begin
                            drain_cnt_q <= DRN_W'(MEM_LAT - 1);
                            state_q     <= StDrain;
                        end
                    end
                end

                StDrain: begin
                    // Last tag leaves the pipe as this count expires.
                    if (drain_cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DRN_W'(1);
                    end
                end

                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    logic [TAG_W-1:0] tag_in;
    logic [TAG_W-1:0] tag_out;

    assign tag_in = {iss_valid_q, iss_row_q, iss_tap_q, iss_last_q};

    sched_tag_pipe #(
        .LAT   (MEM_LAT),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk  (clk),
        .rstn (rstn),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign {feed_valid, feed_row, feed_tap, feed_last} = tag_out;

    assign mem_cen  = mem_cen_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
